// File: rtl/sound_pkg.sv
// Shared encodings for the sound front-end: sound ids, FSM states, divider width.
package sound_pkg;

  localparam int unsigned DIV_W = 17;

  // Sound ids double as priority: a larger code wins.
  localparam logic [1:0] SND_NONE = 2'b00;
  localparam logic [1:0] SND_MOVE = 2'b01;
  localparam logic [1:0] SND_SHOT = 2'b10;
  localparam logic [1:0] SND_EXPL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_GAP  = 2'b10
  } state_t;

  // Priority encoder: explosion > shot > move.
  function automatic logic [1:0] req_to_id(input logic mv, input logic sh, input logic ex);
    logic [1:0] id;
    id = SND_NONE;
    if (ex) begin
      id = SND_EXPL;
    end else if (sh) begin
      id = SND_SHOT;
    end else if (mv) begin
      id = SND_MOVE;
    end
    return id;
  endfunction

endpackage

// File: rtl/tone_divider.sv
// Square-wave generator: toggles the output every half_period cycles while run is high.
module tone_divider
  import sound_pkg::*;
(
  input  logic             CLK,
  input  logic             Rst,
  input  logic             clear,
  input  logic             run,
  input  logic [DIV_W-1:0] half_period,
  output logic             wave
);

  logic [DIV_W-1:0] cnt_q;
  logic             wave_q;

  // Count 0..half_period-1, wrap and toggle; clear forces a silent, zeroed divider.
  always_ff @(posedge CLK) begin
    if (!Rst || clear) begin
      cnt_q  <= '0;
      wave_q <= 1'b0;
    end else if (run) begin
      if (cnt_q >= half_period - DIV_W'(1)) begin
        cnt_q  <= '0;
        wave_q <= ~wave_q;
      end else begin
        cnt_q <= cnt_q + DIV_W'(1);
      end
    end
  end

  assign wave = wave_q;

endmodule

// File: rtl/sound_tone_gen.sv
// Sound front-end: priority-selects a sound request, enables the duration timer while it
// plays and drives the speaker square wave. Optional macro SOUND_PENDING_EN adds a one-deep
// pending slot for requests arriving while busy; without it such requests are dropped.
module sound_tone_gen
  import sound_pkg::*;
#(
  parameter int unsigned HALF_MOVE = 62_500,
  parameter int unsigned HALF_SHOT = 25_000,
  parameter int unsigned HALF_EXPL = 100_000
) (
  input  logic       CLK,
  input  logic       Rst,
  input  logic       ReqMove,
  input  logic       ReqShot,
  input  logic       ReqExpl,
  input  logic       Conto,
  output logic       EN,
  output logic       Speaker,
  output logic       Busy,
  output logic [1:0] SoundId
);

  localparam logic [DIV_W-1:0] HalfMoveW = DIV_W'(HALF_MOVE);
  localparam logic [DIV_W-1:0] HalfShotW = DIV_W'(HALF_SHOT);
  localparam logic [DIV_W-1:0] HalfExplW = DIV_W'(HALF_EXPL);

  state_t           state_q;
  logic             en_q;
  logic             busy_q;
  logic [1:0]       id_q;
  logic [1:0]       req_id;
  logic [1:0]       start_id;
  logic             start;
  logic             pend_valid;
  logic [1:0]       pend_id;
  logic [DIV_W-1:0] half_sel;

  assign req_id = req_to_id(ReqMove, ReqShot, ReqExpl);

  // Winner in IDLE: a pending sound beats a fresh request only if it has higher priority.
  always_comb begin
    start_id = req_id;
    if (pend_valid && (pend_id > req_id)) begin
      start_id = pend_id;
    end
  end

  assign start = (state_q == ST_IDLE) && (start_id != SND_NONE);

`ifdef SOUND_PENDING_EN
  logic       pend_valid_q;
  logic [1:0] pend_id_q;

  // Capture busy-time requests, keeping only the highest; consumed when PLAY starts.
  always_ff @(posedge CLK) begin
    if (!Rst) begin
      pend_valid_q <= 1'b0;
      pend_id_q    <= SND_NONE;
    end else if (start) begin
      pend_valid_q <= 1'b0;
      pend_id_q    <= SND_NONE;
    end else if ((state_q != ST_IDLE) && (req_id > pend_id_q)) begin
      pend_valid_q <= 1'b1;
      pend_id_q    <= req_id;
    end
  end

  assign pend_valid = pend_valid_q;
  assign pend_id    = pend_id_q;
`else
  assign pend_valid = 1'b0;
  assign pend_id    = SND_NONE;
`endif

  // Control FSM with registered EN/Busy/SoundId; Conto is only looked at from PLAY onward.
  always_ff @(posedge CLK) begin
    if (!Rst) begin
      state_q <= ST_IDLE;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      id_q    <= SND_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_PLAY;
            en_q    <= 1'b1;
            busy_q  <= 1'b1;
            id_q    <= start_id;
          end
        end
        ST_PLAY: begin
          if (Conto) begin
            state_q <= ST_GAP;
            en_q    <= 1'b0;
            id_q    <= SND_NONE;
          end
        end
        ST_GAP: begin
          if (!Conto) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          en_q    <= 1'b0;
          busy_q  <= 1'b0;
          id_q    <= SND_NONE;
        end
      endcase
    end
  end

  // Half-period follows the sound being played.
  always_comb begin
    half_sel = HalfMoveW;
    case (id_q)
      SND_SHOT: half_sel = HalfShotW;
      SND_EXPL: half_sel = HalfExplW;
      default:  half_sel = HalfMoveW;
    endcase
  end

  tone_divider u_tone_divider (
    .CLK         (CLK),
    .Rst         (Rst),
    .clear       ((state_q == ST_PLAY) && Conto),
    .run         (state_q == ST_PLAY),
    .half_period (half_sel),
    .wave        (Speaker)
  );

  assign EN      = en_q;
  assign Busy    = busy_q;
  assign SoundId = id_q;

endmodule

// File: doc/sound_tone_gen.md
# sound_tone_gen

Sound front-end feeding the sound-duration timer (quarter-second prescaler plus repeat counter). Accepts one-cycle sound requests from game logic (move, shot, explosion) and picks one by priority. Asserts EN to the duration timer while the sound plays and drives a square-wave speaker output at the selected tone frequency. Stops when the timer returns Conto.

## Interface
Parameters:
- HALF_MOVE, 62_500: half-period in CLK cycles of the move tone (400 Hz at 50 MHz).
- HALF_SHOT, 25_000: half-period of the shot tone (1 kHz).
- HALF_EXPL, 100_000: half-period of the explosion tone (250 Hz).
- All half-periods lie in 2..131_071 (17-bit divider).

Ports:
- CLK  in  1  system clock; one clock domain, all logic on the rising edge.
- Rst  in  1  synchronous, active-low reset.
- ReqMove  in  1  one-cycle request for the move sound.
- ReqShot  in  1  one-cycle request for the shot sound.
- ReqExpl  in  1  one-cycle request for the explosion sound.
- Conto  in  1  done flag from the duration timer; high means the duration has elapsed.
- EN  out  1  enable to the duration timer; high throughout PLAY.
- Speaker  out  1  square-wave audio output.
- Busy  out  1  high in PLAY and GAP.
- SoundId  out  2  sound currently playing: 00 none, 01 move, 10 shot, 11 explosion.

## Operation
- Priority when requests arrive together: explosion > shot > move.
- States:
  - IDLE: EN=0, Speaker=0, SoundId=00.
    - Any request, or a valid pending slot, latches the winning id and moves to PLAY.
    - A pending slot beats a fresh request of lower priority.
  - PLAY: EN=1.
    - The 17-bit divider counts 0..HALF−1; at HALF−1 it wraps to 0 and Speaker toggles.
    - Conto=1 moves to GAP, clears Speaker and the divider, and drops EN.
  - GAP: EN=0, Speaker=0.
    - Stays until Conto=0, minimum 1 cycle, then returns to IDLE.
- Requests arriving during PLAY or GAP follow SOUND_PENDING_EN.
- Reset (Rst=0 on any edge, including mid-PLAY) gives:
  - state IDLE
  - EN=0, Speaker=0, Busy=0, SoundId=00
  - divider 0, pending slot empty.
- A Conto=1 that arrives in the same cycle as the transition into PLAY is ignored; Conto is sampled from the first PLAY cycle onward.

## Timing
- Request sampled at edge N: state=PLAY, EN=1, Busy=1 and SoundId valid after edge N+1.
- First Speaker toggle (0→1) after edge N+1+HALF. Subsequent toggles every HALF cycles.
- Conto high sampled at edge M in PLAY: EN=0 and Speaker=0 after edge M.
- Pending sound starts at the earliest one cycle after leaving GAP, via one IDLE cycle.
- Outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- Macro SOUND_PENDING_EN.
- Defined: a one-deep pending slot captures requests made during PLAY or GAP.
  - A higher-priority request overwrites the slot; an equal or lower one is dropped.
  - The slot is consumed on entry to PLAY.
- Undefined: requests while Busy=1 are dropped and no pending logic is built.

## Structure
- Shared package sound_pkg holds:
  - the SoundId encoding constants (SND_NONE, SND_MOVE, SND_SHOT, SND_EXPL)
  - the state encoding (ST_IDLE, ST_PLAY, ST_GAP)
  - the divider width constant (17).
- Sub-module tone_divider:
  - inputs CLK, Rst, clear, run, 17-bit half-period
  - output toggling square wave
  - instantiated once; the FSM and priority logic stay in sound_tone_gen.

## Test plan
Bench uses HALF_MOVE=6, HALF_SHOT=2, HALF_EXPL=4 and a behavioural Conto model.
- Simple shot: ReqShot pulse at cycle 10, Conto raised at cycle 30 → EN 1 over cycles 11..30, SoundId=10, Speaker toggles every 2 cycles from cycle 13, EN=0 and Speaker=0 at cycle 31.
- Simultaneous requests: ReqMove, ReqShot and ReqExpl in the same cycle → SoundId=11 and Speaker half-period 4.
- Pending (macro on): ReqMove, then ReqShot in PLAY, then ReqExpl in PLAY → after GAP and one IDLE cycle, explosion plays; shot discarded.
- Pending (macro off): same stimulus → only move plays; Busy returns to 0 and stays 0.
- Reset mid-PLAY: Rst=0 for one cycle during explosion → next cycle EN=0, Speaker=0, SoundId=00; a new ReqMove starts normally.
- Conto held high: Conto stays high for 5 cycles after done → block remains in GAP with Busy=1 until Conto falls, then IDLE.
